// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor and the PLL and core-reset logic around it.
// The master modport is the supervisor side. The slave modport is the environment side.
interface pll_lock_supervisor_if;
   logic       pll_locked;
   logic       relock_req;
   logic       pll_resetb;
   logic       core_reset_n;
   logic       ready;
   logic       fault;
   logic       lock_lost;
   logic [3:0] retry_count;
   logic [7:0] loss_count;

   modport master (
      input  pll_locked, relock_req,
      output pll_resetb, core_reset_n, ready, fault, lock_lost, retry_count, loss_count
   );

   modport slave (
      output pll_locked, relock_req,
      input  pll_resetb, core_reset_n, ready, fault, lock_lost, retry_count, loss_count
   );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Brings up the iCE40 PLL from the 12 MHz reference clock and holds the core in reset until LOCK is stable.
// Failed lock attempts are retried a bounded number of times. Loss of lock or a relock request restarts the sequence.
module pll_lock_supervisor #(
   parameter int unsigned PLL_RESET_CYCLES    = 12,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 12000,
   parameter int unsigned LOCK_STABLE_CYCLES  = 1200,
   parameter int unsigned MAX_RETRIES         = 3,
   parameter int unsigned CNT_W               = 16
) (
   input  logic                  clock_in,
   input  logic                  reset_n,
   pll_lock_supervisor_if.master sup
);

   localparam longint unsigned CNT_SPAN = 64'd1 << CNT_W;

   if (PLL_RESET_CYCLES < 1 || LOCK_TIMEOUT_CYCLES < 1 || LOCK_STABLE_CYCLES < 1 ||
       MAX_RETRIES < 1 || MAX_RETRIES > 15 ||
       longint'(PLL_RESET_CYCLES) > CNT_SPAN || longint'(LOCK_TIMEOUT_CYCLES) > CNT_SPAN ||
       longint'(LOCK_STABLE_CYCLES) > CNT_SPAN) begin : g_bad_cfg
      $error("pll_lock_supervisor: illegal parameter set");
   end

   localparam logic [2:0] S_PLL_RST   = 3'd0;
   localparam logic [2:0] S_WAIT_LOCK = 3'd1;
   localparam logic [2:0] S_STABLE    = 3'd2;
   localparam logic [2:0] S_RUN       = 3'd3;
   localparam logic [2:0] S_FAULT     = 3'd4;

   localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PLL_RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [3:0]       RETRY_LAST = 4'(MAX_RETRIES - 1);

   logic [2:0]       r_state;
   logic [CNT_W-1:0] r_timer;
   logic             r_sync1;
   logic             r_sync2;
   logic [3:0]       r_retry;
   logic [7:0]       r_loss;
   logic             r_lock_lost;

   logic [2:0]       w_state_nxt;
   logic [CNT_W-1:0] w_timer_nxt;
   logic [3:0]       w_retry_nxt;
   logic [7:0]       w_loss_nxt;
   logic             w_lost_nxt;
   logic             w_fail;

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= sup.pll_locked;
         r_sync2 <= r_sync1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_retry_nxt = r_retry;
      w_loss_nxt  = r_loss;
      w_lost_nxt  = 1'b0;
      w_fail      = 1'b0;

      case (r_state)
         S_PLL_RST: begin
            if (r_timer == RST_LAST) begin
               w_state_nxt = S_WAIT_LOCK;
               w_timer_nxt = '0;
            end else begin
               w_timer_nxt = r_timer + 1'b1;
            end
         end
         // Lock is tested ahead of the timeout, so a lock arriving in the last cycle still counts.
         S_WAIT_LOCK: begin
            if (r_sync2) begin
               w_state_nxt = S_STABLE;
               w_timer_nxt = '0;
            end else if (r_timer == TO_LAST) begin
               w_fail = 1'b1;
            end else begin
               w_timer_nxt = r_timer + 1'b1;
            end
         end
         S_STABLE: begin
            if (!r_sync2) begin
               w_fail = 1'b1;
            end else if (r_timer == STAB_LAST) begin
               w_state_nxt = S_RUN;
               w_timer_nxt = '0;
            end else begin
               w_timer_nxt = r_timer + 1'b1;
            end
         end
         S_RUN: begin
            if (!r_sync2) begin
               w_state_nxt = S_PLL_RST;
               w_timer_nxt = '0;
               w_retry_nxt = '0;
               w_lost_nxt  = 1'b1;
               if (r_loss != '1) w_loss_nxt = r_loss + 8'd1;
            end
         end
         S_FAULT: begin
            w_timer_nxt = '0;
         end
         default: begin
            w_state_nxt = S_PLL_RST;
            w_timer_nxt = '0;
         end
      endcase

      if (w_fail) begin
         w_retry_nxt = r_retry + 4'd1;
         w_timer_nxt = '0;
         w_state_nxt = (r_retry == RETRY_LAST) ? S_FAULT : S_PLL_RST;
      end

      // A relock request overrides everything decided above, including a loss of lock in the same cycle.
      if (sup.relock_req && (r_state != S_PLL_RST)) begin
         w_state_nxt = S_PLL_RST;
         w_timer_nxt = '0;
         w_retry_nxt = '0;
         w_loss_nxt  = r_loss;
         w_lost_nxt  = 1'b0;
      end
   end

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_PLL_RST;
         r_timer     <= '0;
         r_retry     <= '0;
         r_loss      <= '0;
         r_lock_lost <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_timer     <= w_timer_nxt;
         r_retry     <= w_retry_nxt;
         r_loss      <= w_loss_nxt;
         r_lock_lost <= w_lost_nxt;
      end
   end

   assign sup.pll_resetb   = (r_state != S_PLL_RST);
   assign sup.core_reset_n = (r_state == S_RUN);
   assign sup.ready        = (r_state == S_RUN);
   assign sup.fault        = (r_state == S_FAULT);
   assign sup.lock_lost    = r_lock_lost;
   assign sup.retry_count  = r_retry;
   assign sup.loss_count   = r_loss;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed and randomized bring-up, retry, loss, relock and reset scenarios for pll_lock_supervisor.
// Expected values are derived from the supervisor's timing rules as closed-form cycle counts.
module tb_pll_lock_supervisor;
   localparam int PRC = 4;
   localparam int TO  = 20;
   localparam int ST  = 8;
   localparam int MR  = 2;
   localparam int LAT = ST + 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;
   int   exp_loss = 0;

   always #5 clk = ~clk;

   pll_lock_supervisor_if bus ();

   pll_lock_supervisor #(
      .PLL_RESET_CYCLES   (PRC),
      .LOCK_TIMEOUT_CYCLES(TO),
      .LOCK_STABLE_CYCLES (ST),
      .MAX_RETRIES        (MR),
      .CNT_W              (16)
   ) dut (
      .clock_in(clk),
      .reset_n (rst_n),
      .sup     (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic low_len(output int n, output int nl);
      n = 0;
      nl = 0;
      while (bus.pll_resetb === 1'b0 && n < 200) begin
         if (bus.lock_lost === 1'b1) nl++;
         n++;
         tick();
      end
   endtask

   task automatic high_len(input int lim, output int n, output int core_hi);
      n = 0;
      core_hi = 0;
      while (bus.pll_resetb === 1'b1 && n < lim) begin
         if (bus.core_reset_n !== 1'b0) core_hi++;
         n++;
         tick();
      end
   endtask

   task automatic ready_lat(output int n);
      n = 0;
      while (bus.ready !== 1'b1 && n < 200) begin
         n++;
         tick();
      end
   endtask

   initial begin
      int n, nl, ch, d;
      bus.pll_locked = 1'b0;
      bus.relock_req = 1'b0;
      rst_n = 1'b0;
      repeat (3) tick();

      chk("rst_pll_resetb", bus.pll_resetb, 0);
      chk("rst_core_reset_n", bus.core_reset_n, 0);
      chk("rst_ready", bus.ready, 0);
      chk("rst_fault", bus.fault, 0);
      chk("rst_lock_lost", bus.lock_lost, 0);
      chk("rst_retry", bus.retry_count, 0);
      chk("rst_loss", bus.loss_count, 0);
      rst_n = 1'b1;

      // Nominal bring-up: the lock rises 6 cycles into WAIT_LOCK.
      low_len(n, nl);
      chk("t1_rst_len", n, PRC);
      repeat (6) tick();
      bus.pll_locked = 1'b1;
      ready_lat(n);
      chk("t1_ready_lat", n, LAT);
      chk("t1_core", bus.core_reset_n, 1);
      chk("t1_retry", bus.retry_count, 0);
      chk("t1_fault", bus.fault, 0);

      // Loss of lock while in RUN.
      repeat ($urandom_range(0, 5)) tick();
      bus.pll_locked = 1'b0;
      tick(); tick();
      chk("t4_core_d2", bus.core_reset_n, 1);
      tick();
      exp_loss++;
      chk("t4_core_d3", bus.core_reset_n, 0);
      chk("t4_lost_d3", bus.lock_lost, 1);
      chk("t4_loss", bus.loss_count, exp_loss);
      chk("t4_retry", bus.retry_count, 0);
      low_len(n, nl);
      chk("t4_rst_len", n, PRC);
      chk("t4_lost_pulses", nl, 1);

      // Unstable lock: high for 5 cycles, which is shorter than the stable window.
      repeat ($urandom_range(0, 10)) tick();
      bus.pll_locked = 1'b1;
      repeat (5) tick();
      bus.pll_locked = 1'b0;
      tick(); tick();
      chk("t2_resetb_r7", bus.pll_resetb, 1);
      tick();
      chk("t2_resetb_r8", bus.pll_resetb, 0);
      chk("t2_retry", bus.retry_count, 1);
      low_len(n, nl);
      chk("t2_rst_len", n, PRC);
      repeat ($urandom_range(0, TO - 3)) tick();
      bus.pll_locked = 1'b1;
      ready_lat(n);
      chk("t2_ready_lat", n, LAT);
      chk("t2_retry_run", bus.retry_count, 1);

      // A relock request in the same cycle as the synced lock drop in RUN.
      bus.pll_locked = 1'b0;
      tick(); tick();
      chk("t5b_core_d2", bus.core_reset_n, 1);
      bus.relock_req = 1'b1;
      tick();
      bus.relock_req = 1'b0;
      chk("t5b_core_d3", bus.core_reset_n, 0);
      chk("t5b_loss", bus.loss_count, exp_loss);
      chk("t5b_retry", bus.retry_count, 0);
      low_len(n, nl);
      chk("t5b_rst_len", n, PRC);
      chk("t5b_lost_pulses", nl, 0);

      // Retries exhausted: the lock never arrives.
      high_len(100, n, ch);
      chk("t3_timeout1", n, TO);
      chk("t3_retry1", bus.retry_count, 1);
      low_len(n, nl);
      chk("t3_rst_len2", n, PRC);
      repeat (TO - 1) tick();
      chk("t3_fault_early", bus.fault, 0);
      tick();
      chk("t3_fault", bus.fault, 1);
      chk("t3_retry2", bus.retry_count, MR);
      high_len(50, n, ch);
      chk("t3_no_pulse", n, 50);
      chk("t3_core_low", ch, 0);

      // Leaving FAULT with a relock request, then locking on the last legal cycle.
      bus.relock_req = 1'b1;
      tick();
      bus.relock_req = 1'b0;
      chk("t5a_fault", bus.fault, 0);
      chk("t5a_retry", bus.retry_count, 0);
      low_len(n, nl);
      chk("t5a_rst_len", n, PRC);
      repeat (TO - 3) tick();
      bus.pll_locked = 1'b1;
      ready_lat(n);
      chk("t5a_edge_lat", n, LAT);
      chk("t5a_edge_retry", bus.retry_count, 0);

      // Repeated losses with random timing; loss_count must saturate.
      for (int i = 0; i < 300; i++) begin
         repeat ($urandom_range(0, 4)) tick();
         bus.pll_locked = 1'b0;
         repeat (3) tick();
         exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
         chk("t6_loss", bus.loss_count, exp_loss);
         low_len(n, nl);
         chk("t6_lost_pulses", nl, 1);
         d = $urandom_range(0, TO - 3);
         repeat (d) tick();
         bus.pll_locked = 1'b1;
         ready_lat(n);
         chk("t6_ready_lat", n, LAT);
      end
      chk("t6_loss_sat", bus.loss_count, 255);

      // Asynchronous reset in the middle of STABLE.
      bus.pll_locked = 1'b0;
      repeat (3) tick();
      low_len(n, nl);
      bus.pll_locked = 1'b1;
      repeat (5) tick();
      chk("t6_pre_ready", bus.ready, 0);
      chk("t6_pre_resetb", bus.pll_resetb, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_async_resetb", bus.pll_resetb, 0);
      chk("t6_async_core", bus.core_reset_n, 0);
      chk("t6_async_ready", bus.ready, 0);
      chk("t6_async_fault", bus.fault, 0);
      chk("t6_async_lost", bus.lock_lost, 0);
      chk("t6_async_retry", bus.retry_count, 0);
      chk("t6_async_loss", bus.loss_count, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
